// File: rtl/regfile_sb.sv
// regfile_sb: MIPS register file with main/link/flag write arbitration, optional
// write-to-read bypass, pending-write scoreboard and saturating dropped-write counter.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31,
  parameter int FLAG_REG = 30,
  parameter int BYPASS   = 1,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   ra_addr,
  output logic [DATA_W-1:0]   ra_data,
  output logic                ra_busy,
  input  logic [ADDR_W-1:0]   rb_addr,
  output logic [DATA_W-1:0]   rb_data,
  output logic                rb_busy,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                link_we,
  input  logic [DATA_W-1:0]   link_data,
  input  logic                flag_set,
  input  logic                flag_clr,
  input  logic                sb_set,
  input  logic [ADDR_W-1:0]   sb_addr,
  output logic [ERRCNT_W-1:0] err_cnt
);
  localparam int NUM_REGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);
  localparam logic [ADDR_W-1:0] FLAG_A = ADDR_W'(FLAG_REG);
  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_sb;
  logic [ERRCNT_W-1:0] r_err;
  logic                w_main, w_link, w_flag, w_flag_req;
  logic [1:0]          w_drops;
  logic [ERRCNT_W:0]   w_err_sum;
  logic [DATA_W-1:0]   w_flag_val;
  // Winning sources; reset discards everything in flight so outputs stay zero.
  assign w_flag_req = flag_set | flag_clr;
  assign w_main     = !reset && we && waddr != '0;
  assign w_link     = !reset && link_we && LINK_A != '0 && !(w_main && waddr == LINK_A);
  assign w_flag     = !reset && w_flag_req && FLAG_A != '0 && !(w_main && waddr == FLAG_A)
                      && !(link_we && LINK_A == FLAG_A);
  assign w_flag_val = DATA_W'(flag_set);
  assign w_drops    = 2'(we && waddr == '0) + 2'(link_we && !w_link) + 2'(w_flag_req && !w_flag);
  assign w_err_sum  = {1'b0, r_err} + (ERRCNT_W+1)'(w_drops);
  assign err_cnt    = r_err;
  function automatic logic [DATA_W-1:0] f_rd(input logic [ADDR_W-1:0] a);
    return (a == '0) ? '0 :
           (BYPASS != 0 && w_main && waddr == a) ? wdata :
           (BYPASS != 0 && w_link && LINK_A == a) ? link_data :
           (BYPASS != 0 && w_flag && FLAG_A == a) ? w_flag_val : r_regs[a];
  endfunction
  // A same-cycle main write clears the hazard early unless a new issue re-marks it.
  function automatic logic f_busy(input logic [ADDR_W-1:0] a);
    return a != '0 && r_sb[a] &&
           !(BYPASS != 0 && w_main && waddr == a && !(sb_set && sb_addr == a));
  endfunction
  always_comb begin
    ra_data = f_rd(ra_addr);
    rb_data = f_rd(rb_addr);
    ra_busy = f_busy(ra_addr);
    rb_busy = f_busy(rb_addr);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_sb  <= '0;
      r_err <= '0;
    end else begin
      if (w_main) r_regs[waddr] <= wdata;
      if (w_link) r_regs[LINK_A] <= link_data;
      if (w_flag) r_regs[FLAG_A] <= w_flag_val;
      for (int i = 1; i < NUM_REGS; i++)
        r_sb[i] <= (sb_set && sb_addr == ADDR_W'(i)) ? 1'b1 :
                   (w_main && waddr == ADDR_W'(i)) ? 1'b0 : r_sb[i];
      r_err <= w_err_sum[ERRCNT_W] ? '1 : w_err_sum[ERRCNT_W-1:0];
    end
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised general-purpose register file for the MIPS datapath. It provides two combinational read ports and a primary write port, plus dedicated link-register and flag-register side ports. It adds fixed write arbitration, optional write-to-read bypass, a per-register pending-write scoreboard for hazard detection, and a saturating dropped-write counter. It sits between decode (reads, scoreboard issue) and writeback (commit).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W
LINK_REG, 31, index written by the link port (jal)
FLAG_REG, 30, index written by the flag port
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only
ERRCNT_W, 8, width of the dropped-write counter

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state
ra_addr  in  ADDR_W  read port A address
ra_data  out  DATA_W  read port A data
ra_busy  out  1  register A has a pending write
rb_addr  in  ADDR_W  read port B address
rb_data  out  DATA_W  read port B data
rb_busy  out  1  register B has a pending write
we  in  1  primary write enable
waddr  in  ADDR_W  primary write address
wdata  in  DATA_W  primary write data
link_we  in  1  write link_data to LINK_REG
link_data  in  DATA_W  return address
flag_set  in  1  write 1 to FLAG_REG
flag_clr  in  1  write 0 to FLAG_REG
sb_set  in  1  mark sb_addr pending (instruction issued)
sb_addr  in  ADDR_W  scoreboard issue address
err_cnt  out  ERRCNT_W  saturating dropped-write count

Behaviour:
- Reset (async): all registers 0, all scoreboard bits 0, err_cnt 0. Outputs then reflect a zero state: data 0, busy 0.
- Register 0 reads as 0 always, is never written, and is never marked busy.
- Per-cycle write sources are main (we, waddr != 0), link (link_we), and flag (flag_set | flag_clr).
- Fixed priority on the same target index: main > link > flag. The losing source is discarded.
- Writes to different indices commit in the same edge.
- If flag_set and flag_clr are both 1, set wins and writes 1, zero-extended to DATA_W.
- Dropped writes increment err_cnt once per dropped source per cycle, max +2. err_cnt saturates at all-ones. Dropped writes are:
  - we=1 with waddr=0
  - link or flag write losing arbitration
- Reads are combinational. With BYPASS=1, if a winning write targets the read address this cycle, data = the winning write value; otherwise data = the stored value. With BYPASS=0, data = the stored value.
- Scoreboard updates per index on each edge:
  - sb_set to that index (index != 0): bit = 1
  - else a winning main write to that index: bit = 0
  - else: bit holds
  - Link and flag writes never clear the scoreboard.
- ra_busy/rb_busy = scoreboard bit of the address.
- With BYPASS=1, busy is forced to 0 when a winning main write to that address occurs this cycle and sb_set does not target it this cycle.
- busy for address 0 is always 0.
- Write latency: stored value visible one edge after the write; bypassed value visible the same cycle.
- Reset asserted mid-operation: all in-flight writes and sb_set are discarded; state is 0 until reset deasserts.

Test Plan:
- Reset then read all 32 addresses on both ports -> every data 0, busy 0, err_cnt 0.
- we=1, waddr=5, wdata=0xDEADBEEF, ra_addr=5 -> ra_data=0xDEADBEEF the same cycle (BYPASS=1) and after the edge. Repeat with BYPASS=0 -> 0 before the edge, 0xDEADBEEF after.
- Same cycle: we to 31 with 0x11, link_we with 0x22, flag_set -> reg31=0x11, reg30=1, err_cnt=1. Next cycle: link_we=0x40 plus flag_set and flag_clr together -> reg31=0x40, reg30=1.
- we=1, waddr=0, wdata=0xFFFFFFFF -> reg0 still reads 0, err_cnt increments by 1. Force 300 such cycles -> err_cnt=255.
- sb_set addr 7 -> rb_busy=1 for addr 7 next cycle. Main write to 7 -> busy 0 the same cycle (bypass) and after the edge. sb_set and write to 7 in the same cycle -> busy remains 1.
- Write 0x1234 to reg 9 and sb_set 9, assert reset mid-cycle -> immediately reg9=0, busy 0. A write issued during reset is not stored.
